// File: rtl/ascii_msg_pkg.sv
// ascii_msg_pkg: message constants and KMP failure tables shared by the ASCII generator and receiver
package ascii_msg_pkg;
    typedef logic [7:0] char_t;
    localparam int LEN_A = 9;
    localparam int LEN_B = 7;
    localparam char_t [0:LEN_A-1] WORD_A = {8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
    localparam char_t [0:LEN_B-1] WORD_B = {8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
    localparam logic [0:LEN_A-1][3:0] FAIL_A = '0;
    localparam logic [0:LEN_B-1][3:0] FAIL_B = {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
endpackage

// File: rtl/word_matcher.sv
// word_matcher: streaming recogniser for one fixed word with single-step KMP fallback and saturating hit counter
module word_matcher
    import ascii_msg_pkg::*;
#(
    parameter int LEN = LEN_A,
    parameter char_t [0:LEN-1] WORD = WORD_A,
    parameter logic [0:LEN-1][3:0] FAIL = FAIL_A,
    parameter int COUNT_W = 8,
    localparam int IW = $clog2(LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  char_t              data,
    input  logic               valid,
    input  logic               clear,
    output logic               match,
    output logic [COUNT_W-1:0] count,
    output logic [IW-1:0]      progress
);
    logic [IW-1:0] idx, nxt, f;
    logic hit, done;
    always_comb begin
        f = IW'(FAIL[idx]);
        hit = data == WORD[idx];
        done = valid && hit && idx == IW'(LEN - 1);
        nxt = hit ? (done ? '0 : idx + 1'b1) :
              data == WORD[f] ? f + 1'b1 :
              data == WORD[0] ? IW'(1) : '0;
    end
    // clear has priority over a same-cycle completion; the pulse is unaffected
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
            match <= 1'b0;
            count <= '0;
        end else begin
            match <= done;
            if (valid) idx <= nxt;
            if (clear) count <= '0;
            else if (done && count != '1) count <= count + 1'b1;
        end
    end
    assign progress = idx;
endmodule

// File: rtl/ascii_word_rx.sv
// ascii_word_rx: recognises "Guatemala" and "QQuetza" in a byte stream with per-word pulses and counters
module ascii_word_rx
    import ascii_msg_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  char_t              data_in,
    input  logic               data_valid,
    input  logic               clear_counts,
    output logic               match_a,
    output logic               match_b,
    output logic [COUNT_W-1:0] count_a,
    output logic [COUNT_W-1:0] count_b,
    output logic [3:0]         progress_a,
    output logic [2:0]         progress_b
);
    word_matcher #(.LEN(LEN_A), .WORD(WORD_A), .FAIL(FAIL_A), .COUNT_W(COUNT_W)) u_a (
        .clk(clk), .reset(reset), .data(data_in), .valid(data_valid), .clear(clear_counts),
        .match(match_a), .count(count_a), .progress(progress_a)
    );
    word_matcher #(.LEN(LEN_B), .WORD(WORD_B), .FAIL(FAIL_B), .COUNT_W(COUNT_W)) u_b (
        .clk(clk), .reset(reset), .data(data_in), .valid(data_valid), .clear(clear_counts),
        .match(match_b), .count(count_b), .progress(progress_b)
    );
endmodule

// File: tb/tb_ascii_word_rx.sv
// tb_ascii_word_rx: directed and random streams checked against a longest-suffix reference model
module tb_ascii_word_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       clear_counts = 1'b0;
    logic       match_a, match_b;
    logic [7:0] count_a, count_b;
    logic [3:0] progress_a;
    logic [2:0] progress_b;

    ascii_word_rx #(.COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_counts(clear_counts), .match_a(match_a), .match_b(match_b),
        .count_a(count_a), .count_b(count_b), .progress_a(progress_a), .progress_b(progress_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    byte words[2][9];
    int lens[2] = '{9, 7};
    byte hist[2][$];
    int exp_match[2];
    int exp_count[2];
    int exp_prog[2];

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // longest suffix of the history that equals a prefix of the word (length up to the full word)
    function automatic int suffix_len(int w);
        for (int k = lens[w]; k > 0; k--) begin
            if (k <= hist[w].size()) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (hist[w][hist[w].size() - k + j] != words[w][j]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model(input logic v, input byte d, input logic clr, input logic r);
        for (int w = 0; w < 2; w++) begin
            exp_match[w] = 0;
            if (r) begin
                hist[w].delete();
                exp_count[w] = 0;
                exp_prog[w] = 0;
            end else begin
                if (v) begin
                    int k;
                    hist[w].push_back(d);
                    if (hist[w].size() > lens[w]) void'(hist[w].pop_front());
                    k = suffix_len(w);
                    if (k == lens[w]) begin
                        exp_match[w] = 1;
                        hist[w].delete();
                        exp_prog[w] = 0;
                        if (exp_count[w] < 255) exp_count[w]++;
                    end else exp_prog[w] = k;
                end
                if (clr) exp_count[w] = 0;
            end
        end
    endtask

    task automatic cyc(input logic v, input byte d, input logic clr, input logic r);
        @(negedge clk);
        data_valid = v;
        data_in = d;
        clear_counts = clr;
        reset = r;
        @(posedge clk);
        model(v, d, clr, r);
        #1;
        chk("match_a", int'(match_a), exp_match[0]);
        chk("match_b", int'(match_b), exp_match[1]);
        chk("count_a", int'(count_a), exp_count[0]);
        chk("count_b", int'(count_b), exp_count[1]);
        chk("progress_a", int'(progress_a), exp_prog[0]);
        chk("progress_b", int'(progress_b), exp_prog[1]);
    endtask

    task automatic send(input string s, input bit stall);
        for (int i = 0; i < s.len(); i++) begin
            if (stall && $urandom_range(0, 2) == 0) cyc(1'b0, byte'($urandom), 1'b0, 1'b0);
            cyc(1'b1, s[i], 1'b0, 1'b0);
        end
    endtask

    initial begin
        string sa = "Guatemala";
        string sb = "QQuetza";
        string alpha = "GuatemlQz x";
        int a_pulses;
        for (int i = 0; i < 9; i++) words[0][i] = sa[i];
        for (int i = 0; i < 7; i++) words[1][i] = sb[i];
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h47, 1'b0, 1'b1);
        send("Guatemala", 1'b0);
        send("QQQuetza", 1'b0);
        send("GuaGuatemala", 1'b0);
        send("GuatemalGuatemala", 1'b0);
        a_pulses = 0;
        for (int n = 0; n < 300; n++)
            for (int i = 0; i < 9; i++) begin
                cyc(1'b1, sa[i], 1'b0, 1'b0);
                a_pulses += int'(match_a);
            end
        chk("a_pulse_total", a_pulses, 300);
        chk("count_a_sat", int'(count_a), 255);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        send("QQuetza", 1'b0);
        send("QQuetza", 1'b0);
        send("QQuetz", 1'b0);
        cyc(1'b1, "a", 1'b1, 1'b0);
        chk("clear_wins_pulse", int'(match_b), 1);
        chk("clear_wins_count", int'(count_b), 0);
        send("QQuetza", 1'b0);
        send("Guatem", 1'b0);
        cyc(1'b1, "a", 1'b0, 1'b1);
        send("ala", 1'b0);
        send("Guatemala", 1'b1);
        send("QQuetza", 1'b1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 40) == 0) send($urandom_range(0, 1) ? "Guatemala" : "QQQuetza", 1'b1);
            cyc(1'b1 ^ ($urandom_range(0, 4) == 0), alpha[$urandom_range(0, alpha.len() - 1)],
                $urandom_range(0, 60) == 0, $urandom_range(0, 200) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
